// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, state
// encodings, datapath mux/ALU encodings and the decoded strobe bundle.
package mc_ctrl_fsm_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  // Opcode field values (IR[31:26])
  localparam logic [OP_W-1:0] OP_R    = 6'h00;
  localparam logic [OP_W-1:0] OP_J    = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE  = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW   = 6'h23;
  localparam logic [OP_W-1:0] OP_SW   = 6'h2B;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MREAD  = 4'd3,
    S_MWB    = 4'd4,
    S_MWRITE = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JAL    = 4'd12,
    S_EXC    = 4'd13
  } state_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  localparam logic [1:0] ASB_B      = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Decoded datapath strobe bundle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       zero_ext;
    logic       cause_write;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  // ALU operation for the immediate-arithmetic group
  function automatic logic [2:0] imm_alu_op(input logic [OP_W-1:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit to datapath bundle.
//   op, mem_ready : datapath -> controller (opcode field, memory completion)
//   state         : controller debug view of the state register
//   strobes       : controller -> datapath control signals
interface mc_ctrl_if;
  import mc_ctrl_fsm_pkg::*;

  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic [STATE_W-1:0] state;
  logic               pc_write;
  logic               pc_write_cond;
  logic               branch_ne;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               alu_src_a;
  logic               reg_write;
  logic               zero_ext;
  logic               cause_write;
  logic [1:0]         pc_source;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_op;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;

  modport master (
    input  op, mem_ready,
    output state, pc_write, pc_write_cond, branch_ne, iord, mem_read,
           mem_write, ir_write, alu_src_a, reg_write, zero_ext, cause_write,
           pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg
  );

  modport slave (
    output op, mem_ready,
    input  state, pc_write, pc_write_cond, branch_ne, iord, mem_read,
           mem_write, ir_write, alu_src_a, reg_write, zero_ext, cause_write,
           pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg
  );

endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational strobe decoder: registered state (+ opcode) -> datapath strobes.
//   state      : current state register value
//   op         : opcode field, stable from DECODE until the next FETCH
//   fetch_done : instruction fetch completes this cycle (gates ir/pc write)
//   ctl        : decoded strobe bundle
module mc_ctrl_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  state_e          state,
  input  logic [OP_W-1:0] op,
  input  logic            fetch_done,
  output ctrl_t           ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = ASB_FOUR;
        ctl.alu_op    = ALU_ADD;
        // IR load and PC+4 only in the cycle memory actually delivers
        ctl.ir_write  = fetch_done;
        ctl.pc_write  = fetch_done;
      end
      S_DECODE: ctl.alu_src_b = ASB_IMM_SH;
      S_MADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ASB_IMM;
      end
      S_MREAD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = M2R_MDR;
      end
      S_MWRITE: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = RDST_RD;
      end
      S_IEXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = ASB_IMM;
        ctl.alu_op    = imm_alu_op(op);
        ctl.zero_ext  = (op == OP_ANDI) || (op == OP_ORI);
      end
      S_IWB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = RDST_RT;
        ctl.mem_to_reg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCS_ALUOUT;
        ctl.branch_ne     = (op == OP_BNE);
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCS_JUMP;
      end
      S_JAL: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = PCS_JUMP;
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = RDST_RA;
        ctl.mem_to_reg = M2R_PC;
      end
      S_EXC: begin
        ctl.pc_write    = 1'b1;
        ctl.pc_source   = PCS_EXC;
        ctl.cause_write = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: state register, next-state logic and strobe
// decode with optional variable-latency memory handshake.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : master side of mc_ctrl_if (op/mem_ready in, state/strobes out)
// MEM_WAIT = 1 stalls FETCH/MREAD/MWRITE until mem_ready; EN_EXC = 1 traps
// illegal opcodes to EXC, otherwise they retire as NOPs.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EN_EXC   = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  mc_ctrl_if.master bus
);

  state_e state_q;
  state_e state_d;
  logic   mem_done_c;
  ctrl_t  dec_c;
  ctrl_t  ctl_c;

  // Memory access completes this cycle
  assign mem_done_c = MEM_WAIT ? bus.mem_ready : 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_done_c ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_J:                                 state_d = S_JUMP;
          OP_JAL:                               state_d = S_JAL;
          OP_BEQ, OP_BNE:                       state_d = S_BRANCH;
          OP_R:                                 state_d = S_EXEC;
          OP_LW, OP_SW:                         state_d = S_MADDR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:    state_d = S_IEXEC;
          default:                              state_d = EN_EXC ? S_EXC : S_FETCH;
        endcase
      end
      S_MADDR:  state_d = (bus.op == OP_LW) ? S_MREAD : S_MWRITE;
      S_MREAD:  state_d = mem_done_c ? S_MWB : S_MREAD;
      S_MWRITE: state_d = mem_done_c ? S_FETCH : S_MWRITE;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state      (state_q),
    .op         (bus.op),
    .fetch_done (mem_done_c),
    .ctl        (dec_c)
  );

  // Strobes are held low for the whole reset assertion, not just after the edge
  assign ctl_c = rst_n ? dec_c : '0;

  assign bus.state         = state_q;
  assign bus.pc_write      = ctl_c.pc_write;
  assign bus.pc_write_cond = ctl_c.pc_write_cond;
  assign bus.branch_ne     = ctl_c.branch_ne;
  assign bus.iord          = ctl_c.iord;
  assign bus.mem_read      = ctl_c.mem_read;
  assign bus.mem_write     = ctl_c.mem_write;
  assign bus.ir_write      = ctl_c.ir_write;
  assign bus.alu_src_a     = ctl_c.alu_src_a;
  assign bus.reg_write     = ctl_c.reg_write;
  assign bus.zero_ext      = ctl_c.zero_ext;
  assign bus.cause_write   = ctl_c.cause_write;
  assign bus.pc_source     = ctl_c.pc_source;
  assign bus.alu_src_b     = ctl_c.alu_src_b;
  assign bus.alu_op        = ctl_c.alu_op;
  assign bus.reg_dst       = ctl_c.reg_dst;
  assign bus.mem_to_reg    = ctl_c.mem_to_reg;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: two instances (stalling memory + traps, and
// single-cycle memory + illegal-as-NOP) checked against an instruction-level
// model that expands each opcode into its expected state walk.
module tb_mc_ctrl_fsm;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   irw_cnt = 0;

  always #5 clk = ~clk;

  mc_ctrl_if ifa ();
  mc_ctrl_if ifb ();

  mc_ctrl_fsm #(.MEM_WAIT(1'b1), .EN_EXC(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mc_ctrl_fsm #(.MEM_WAIT(1'b0), .EN_EXC(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [5:0] legal [11] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                             6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_state(input bit b);
    return b ? 32'(ifb.state) : 32'(ifa.state);
  endfunction

  // Strobe vector: pcw,pcwc,bne,iord,mr,mw,irw,asa,rw,zx,cw,pcs,asb,aop,rd,m2r
  function automatic logic [31:0] get_strb(input bit b);
    if (b)
      return 32'({ifb.pc_write, ifb.pc_write_cond, ifb.branch_ne, ifb.iord, ifb.mem_read,
                  ifb.mem_write, ifb.ir_write, ifb.alu_src_a, ifb.reg_write, ifb.zero_ext,
                  ifb.cause_write, ifb.pc_source, ifb.alu_src_b, ifb.alu_op, ifb.reg_dst,
                  ifb.mem_to_reg});
    return 32'({ifa.pc_write, ifa.pc_write_cond, ifa.branch_ne, ifa.iord, ifa.mem_read,
                ifa.mem_write, ifa.ir_write, ifa.alu_src_a, ifa.reg_write, ifa.zero_ext,
                ifa.cause_write, ifa.pc_source, ifa.alu_src_b, ifa.alu_op, ifa.reg_dst,
                ifa.mem_to_reg});
  endfunction

  // Expected strobes for a state number, from the per-state strobe table
  function automatic logic [31:0] exp_strb(input int st, input logic [5:0] o, input bit done);
    logic pcw = 0, pcwc = 0, bne = 0, iord = 0, mr = 0, mw = 0, irw = 0;
    logic asa = 0, rw = 0, zx = 0, cw = 0;
    logic [1:0] pcs = 0, asb = 0, rd = 0, m2r = 0;
    logic [2:0] aop = 0;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = done; pcw = done; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; aop = 3'b010; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; bne = (o == 6'h05); end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin
        asa = 1; asb = 2'b10;
        if (o == 6'h0A) aop = 3'b101;
        else if (o == 6'h0C) begin aop = 3'b011; zx = 1; end
        else if (o == 6'h0D) begin aop = 3'b100; zx = 1; end
      end
      11: rw = 1;
      12: begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      13: begin pcw = 1; pcs = 2'b11; cw = 1; end
      default: ;
    endcase
    return 32'({pcw, pcwc, bne, iord, mr, mw, irw, asa, rw, zx, cw, pcs, asb, aop, rd, m2r});
  endfunction

  // States visited after FETCH for an instruction, ignoring memory stalls
  function automatic void plan(input logic [5:0] o, input bit exc, output int body[$]);
    case (o)
      6'h00:                      body = '{1, 6, 7};
      6'h02:                      body = '{1, 9};
      6'h03:                      body = '{1, 12};
      6'h04, 6'h05:               body = '{1, 8};
      6'h08, 6'h0A, 6'h0C, 6'h0D: body = '{1, 10, 11};
      6'h23:                      body = '{1, 2, 3, 4};
      6'h2B:                      body = '{1, 2, 5};
      default:                    body = exc ? '{1, 13} : '{1};
    endcase
  endfunction

  // One cycle: entered just after a rising edge, checked on the falling edge
  task automatic step(input bit b, input int st, input logic [5:0] o, input bit mr_in, input string tag);
    if (b) ifb.mem_ready = mr_in; else ifa.mem_ready = mr_in;
    @(negedge clk);
    chk({tag, " state"}, get_state(b), 32'(st));
    chk({tag, " strobes"}, get_strb(b), exp_strb(st, o, b ? 1'b1 : mr_in));
    if (!b && ifa.ir_write) irw_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input bit b, input logic [5:0] o, input int wf, input string tag);
    if (b) ifb.op = o; else ifa.op = o;
    if (b) step(b, 0, o, 1'($urandom_range(0, 1)), tag);
    else for (int k = 0; k <= wf; k++) step(b, 0, o, k == wf, tag);
  endtask

  task automatic do_body(input bit b, input logic [5:0] o, input int wm, input string tag);
    int body[$];
    plan(o, !b, body);
    foreach (body[i]) begin
      if (!b && (body[i] == 3 || body[i] == 5))
        for (int k = 0; k <= wm; k++) step(b, body[i], o, k == wm, tag);
      else
        step(b, body[i], o, 1'($urandom_range(0, 1)), tag);
    end
  endtask

  task automatic run(input bit b, input logic [5:0] o, input int wf, input int wm, input string tag);
    do_fetch(b, o, wf, tag);
    do_body(b, o, wm, tag);
  endtask

  // Re-align both instances to FETCH with a short reset pulse inside a cycle
  task automatic resync();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] o;
    ifa.op = 6'h00; ifa.mem_ready = 1'b0;
    ifb.op = 6'h00; ifb.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state a", get_state(0), 32'd0);
    chk("reset strobes a", get_strb(0), 32'd0);
    chk("reset state b", get_state(1), 32'd0);
    chk("reset strobes b", get_strb(1), 32'd0);
    rst_n = 1'b1;

    // LW with three stall cycles in both FETCH and MREAD
    irw_cnt = 0;
    do_fetch(0, 6'h23, 3, "lw_wait");
    do_body(0, 6'h23, 3, "lw_wait");
    chk("lw ir_write pulses", 32'(irw_cnt), 32'd1);

    run(0, 6'h05, 0, 0, "bne");
    run(0, 6'h03, 1, 0, "jal");
    run(0, 6'h0D, 0, 0, "ori");
    run(0, 6'h3F, 2, 0, "illegal_exc");
    run(0, 6'h2B, 0, 2, "sw_wait");

    // Reset asserted mid-MREAD aborts the load immediately
    do_fetch(0, 6'h23, 0, "rst_lw");
    step(0, 1, 6'h23, 1'b1, "rst_lw");
    step(0, 2, 6'h23, 1'b1, "rst_lw");
    ifa.mem_ready = 1'b0;
    @(negedge clk);
    chk("rst pre state", get_state(0), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst async state", get_state(0), 32'd0);
    chk("rst async strobes", get_strb(0), 32'd0);
    @(posedge clk);
    #1;
    chk("rst held state", get_state(0), 32'd0);
    chk("rst held strobes", get_strb(0), 32'd0);
    rst_n = 1'b1;
    step(0, 0, 6'h23, 1'b1, "rst_release");
    do_body(0, 6'h23, 0, "rst_release");

    // Randomised instruction stream on the stalling instance
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) o = 6'($urandom);
      else o = legal[$urandom_range(0, 10)];
      run(0, o, $urandom_range(0, 3), $urandom_range(0, 3), "rand_a");
    end
    do_fetch(0, 6'h00, 0, "tail_a");

    // Single-cycle memory, illegal opcodes retire as NOPs
    @(posedge clk);
    #1;
    resync();
    run(1, 6'h3F, 0, 0, "illegal_nop");
    run(1, 6'h23, 0, 0, "lw_nowait");
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) o = 6'($urandom);
      else o = legal[$urandom_range(0, 10)];
      run(1, o, 0, 0, "rand_b");
    end
    do_fetch(1, 6'h00, 0, "tail_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Registered multicycle control unit for the MIPS datapath; successor to the combinational next-state/decoder control block.
- Owns its own state register.
- Extends the instruction set with BNE, JAL, ADDI, ANDI, ORI, SLTI and illegal-opcode trapping.
- Adds an optional variable-latency memory handshake.
- Sits between the instruction register opcode field and all datapath strobes.

Parameters:
- OP_W, 6, opcode field width.
- STATE_W, 4, state register width (14 states used).
- MEM_WAIT, 1: 1 = memory states stall until mem_ready; 0 = mem_ready ignored, single-cycle memory.
- EN_EXC, 1: 1 = illegal opcodes trap to EXC; 0 = illegal opcodes treated as NOP (DECODE returns to FETCH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  OP_W  IR[31:26].
- mem_ready  in  1  memory access completes this cycle.
- state  out  STATE_W  current state, for debug.
- pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write, alu_src_a, reg_write, zero_ext, cause_write  out  1 each  datapath strobes.
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- alu_op  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: state = FETCH immediately. While rst_n = 0, every output except state is forced to 0.
- Opcodes: R 0x00, J 0x02, JAL 0x03, BEQ 0x04, BNE 0x05, ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D, LW 0x23, SW 0x2B.
- States and transitions:
  - FETCH(0) -> DECODE when done.
  - DECODE(1) dispatch: J -> JUMP(9); JAL -> JAL(12); BEQ/BNE -> BRANCH(8); R -> EXEC(6); LW/SW -> MADDR(2); ADDI/SLTI/ANDI/ORI -> IEXEC(10); other -> EXC(13), or FETCH if EN_EXC = 0.
  - MADDR -> MREAD(3) for LW, MWRITE(5) for SW.
  - MREAD -> MWB(4) when done.
  - MWRITE -> FETCH when done.
  - EXEC -> RWB(7). IEXEC -> IWB(11).
  - MWB, RWB, IWB, BRANCH, JUMP, JAL, EXC -> FETCH.
- "Done" in FETCH, MREAD, MWRITE = mem_ready when MEM_WAIT = 1, otherwise always true. When not done, state holds.
- Strobes per state:
  - FETCH: mem_read = 1 for every cycle in the state; alu_src_b = 01; alu_op = add; ir_write and pc_write asserted only in the done cycle (Mealy gating).
  - DECODE: alu_src_b = 11.
  - MADDR: alu_src_a = 1, alu_src_b = 10.
  - MREAD: mem_read = 1, iord = 1.
  - MWRITE: iord = 1; mem_write = 1 for every cycle in the state.
  - MWB: reg_write = 1, mem_to_reg = 01.
  - EXEC: alu_src_a = 1, alu_op = 010.
  - RWB: reg_write = 1, reg_dst = 01.
  - IEXEC: alu_src_a = 1, alu_src_b = 10; alu_op = add (ADDI), slt (SLTI), and (ANDI), or (ORI); zero_ext = 1 for ANDI/ORI.
  - IWB: reg_write = 1, reg_dst = 00, mem_to_reg = 00.
  - BRANCH: alu_src_a = 1, alu_op = sub, pc_write_cond = 1, pc_source = 01, branch_ne = (op == BNE).
  - JUMP: pc_write = 1, pc_source = 10.
  - JAL: pc_write = 1, pc_source = 10, reg_write = 1, reg_dst = 10, mem_to_reg = 10.
  - EXC: pc_write = 1, pc_source = 11, cause_write = 1.
- Unlisted outputs are 0 in each state.
- All outputs except the FETCH done-gated strobes are a pure decode of the registered state (plus op where stated). op must stay stable from DECODE until the next FETCH; the IR guarantees this.
- Unencoded state values 14–15 -> FETCH next cycle, all strobes 0.
- Reset asserted mid-instruction aborts it: no further strobes; restart at FETCH.
- mem_ready is ignored outside FETCH, MREAD and MWRITE.

Decomposition:
- Shared package: opcode localparams, state encodings, alu_op / pc_source / alu_src_b / reg_dst / mem_to_reg encodings.
- Natural sub-module: mc_ctrl_decode, combinational state+op -> strobe decoder.
- Top module: state register and next-state logic.

Test Plan:
- Reset: rst_n = 0 mid-MREAD -> state = 0 at once, all strobes 0. Release with mem_ready = 1 -> FETCH, with ir_write = 1 and pc_write = 1 in that cycle.
- LW with MEM_WAIT = 1, mem_ready low 3 cycles in both FETCH and MREAD -> sequence 0,0,0,0,1,2,3,3,3,3,4,0. mem_read held the whole time; ir_write pulses exactly once.
- BNE (op = 0x05) -> 0,1,8,0. In state 8: pc_write_cond = 1, branch_ne = 1, alu_op = 001, pc_source = 01.
- JAL (op = 0x03) -> 0,1,12,0. In state 12: reg_dst = 10, mem_to_reg = 10, reg_write = 1, pc_write = 1.
- ORI (op = 0x0D) -> IEXEC with alu_op = 100 and zero_ext = 1, then IWB with reg_write = 1 and reg_dst = 00.
- Illegal op = 0x3F: EN_EXC = 1 -> 1,13,0 with cause_write = 1 and pc_source = 11. EN_EXC = 0 -> 1,0 with no writes.
